// File: rtl/vec_inst_dispatcher_pkg.sv
// Shared types for the vector instruction dispatcher: FSM state encoding,
// the 96-bit queued instruction entry and the saturating statistics helper.
package vec_inst_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_HANDSHAKE = 2'd3
  } disp_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } fifo_entry_t;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vec_inst_dispatcher_if.sv
// Bus bundle between the dispatcher, the scalar core and the vector processor.
// slave: the dispatcher side. master: the environment (core + vector unit).
interface vec_inst_dispatcher_if;

  logic [31:0] push_inst;
  logic [31:0] push_rs1;
  logic [31:0] push_rs2;
  logic        push_valid;
  logic        push_ready;

  logic [31:0] instruction;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        inst_valid;
  logic        vec_pro_ready;
  logic        vec_pro_ack;
  logic        scalar_pro_ready;

  logic        error;
  logic        is_vec;
  logic [31:0] csr_out;

  logic        resp_valid;
  logic        resp_error;
  logic        resp_is_vec;
  logic [31:0] resp_csr;
  logic        busy;

  modport slave (
    input  push_inst, push_rs1, push_rs2, push_valid,
    input  vec_pro_ready, vec_pro_ack, error, is_vec, csr_out,
    output push_ready, instruction, rs1_data, rs2_data, inst_valid,
    output scalar_pro_ready, resp_valid, resp_error, resp_is_vec, resp_csr, busy
  );

  modport master (
    output push_inst, push_rs1, push_rs2, push_valid,
    output vec_pro_ready, vec_pro_ack, error, is_vec, csr_out,
    input  push_ready, instruction, rs1_data, rs2_data, inst_valid,
    input  scalar_pro_ready, resp_valid, resp_error, resp_is_vec, resp_csr, busy
  );

endinterface

// File: rtl/vec_inst_fifo.sv
// Instruction queue for the dispatcher. DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit to tell full from empty.
// The consumer-facing empty flag compares against a one-cycle-delayed copy of
// the write pointer, so a freshly written entry becomes poppable one cycle
// after it lands; occupied reflects the true fill state for status reporting.
module vec_inst_fifo
  import vec_inst_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t pop_data,
  output logic        full,
  output logic        empty,
  output logic        occupied
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fifo_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] wr_vis_q, wr_vis_d;
  logic        do_push;
  logic        do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_vis_q == rd_ptr_q);
  assign occupied = (wr_ptr_q != rd_ptr_q);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointer arithmetic; a push while full is dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_vis_d = wr_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers, cleared by reset to empty the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_vis_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_vis_q <= wr_vis_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vec_inst_dispatcher.sv
// Vector instruction dispatcher: queues instructions from the scalar core,
// issues them one at a time to the vector processor and returns the result.
// Optional build macro DISPATCH_STATS_EN adds saturating issue/error counters
// with a synchronous clear input.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | waiting for a queued instruction and vec_pro_ready
// ST_ISSUE     | inst_valid strobe, one cycle
// ST_WAIT_ACK  | waiting for vec_pro_ack; result captured on ack
// ST_HANDSHAKE | scalar_pro_ready held until the vector unit drops its ack
module vec_inst_dispatcher
  import vec_inst_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  vec_inst_dispatcher_if.slave   bus
`ifdef DISPATCH_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [STAT_W-1:0]      issue_count,
  output logic [STAT_W-1:0]      err_count
`endif
);

  disp_state_e state_q, state_d;
  logic [31:0] instruction_q, instruction_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] rs2_data_q, rs2_data_d;
  logic        inst_valid_q, inst_valid_d;
  logic        scalar_pro_ready_q, scalar_pro_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic        resp_is_vec_q, resp_is_vec_d;
  logic [31:0] resp_csr_q, resp_csr_d;

  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_occupied;
  logic        pop;

  assign push_entry = '{inst: bus.push_inst, rs1: bus.push_rs1, rs2: bus.push_rs2};

  vec_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.push_valid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupied  (fifo_occupied)
  );

  // Dispatch FSM next-state and registered-output decode.
  always_comb begin
    state_d            = state_q;
    instruction_d      = instruction_q;
    rs1_data_d         = rs1_data_q;
    rs2_data_d         = rs2_data_q;
    inst_valid_d       = 1'b0;
    scalar_pro_ready_d = scalar_pro_ready_q;
    resp_valid_d       = 1'b0;
    resp_error_d       = resp_error_q;
    resp_is_vec_d      = resp_is_vec_q;
    resp_csr_d         = resp_csr_q;
    pop                = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && bus.vec_pro_ready) begin
          pop           = 1'b1;
          instruction_d = head.inst;
          rs1_data_d    = head.rs1;
          rs2_data_d    = head.rs2;
          inst_valid_d  = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.vec_pro_ack) begin
          resp_error_d       = bus.error;
          resp_is_vec_d      = bus.is_vec;
          resp_csr_d         = bus.csr_out;
          resp_valid_d       = 1'b1;
          scalar_pro_ready_d = 1'b1;
          state_d            = ST_HANDSHAKE;
        end
      end
      ST_HANDSHAKE: begin
        if (!bus.vec_pro_ack) begin
          scalar_pro_ready_d = 1'b0;
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dispatch FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      instruction_q      <= '0;
      rs1_data_q         <= '0;
      rs2_data_q         <= '0;
      inst_valid_q       <= 1'b0;
      scalar_pro_ready_q <= 1'b0;
      resp_valid_q       <= 1'b0;
      resp_error_q       <= 1'b0;
      resp_is_vec_q      <= 1'b0;
      resp_csr_q         <= '0;
    end else begin
      state_q            <= state_d;
      instruction_q      <= instruction_d;
      rs1_data_q         <= rs1_data_d;
      rs2_data_q         <= rs2_data_d;
      inst_valid_q       <= inst_valid_d;
      scalar_pro_ready_q <= scalar_pro_ready_d;
      resp_valid_q       <= resp_valid_d;
      resp_error_q       <= resp_error_d;
      resp_is_vec_q      <= resp_is_vec_d;
      resp_csr_q         <= resp_csr_d;
    end
  end

  assign bus.push_ready       = !fifo_full;
  assign bus.instruction      = instruction_q;
  assign bus.rs1_data         = rs1_data_q;
  assign bus.rs2_data         = rs2_data_q;
  assign bus.inst_valid       = inst_valid_q;
  assign bus.scalar_pro_ready = scalar_pro_ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_error       = resp_error_q;
  assign bus.resp_is_vec      = resp_is_vec_q;
  assign bus.resp_csr         = resp_csr_q;
  assign bus.busy             = (state_q != ST_IDLE) || fifo_occupied;

`ifdef DISPATCH_STATS_EN
  logic [STAT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;

  // Counter update; clear wins over a same-cycle increment.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (stats_clr) begin
      issue_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (state_q == ST_ISSUE) issue_cnt_d = sat_inc(issue_cnt_q);
      if (state_q == ST_WAIT_ACK && bus.vec_pro_ack && bus.error)
        err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign issue_count = issue_cnt_q;
  assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_vec_inst_dispatcher.sv
// Scoreboard bench for vec_inst_dispatcher: pushes record expected issues,
// a vector-processor model records expected responses, and a monitor checks
// every issue and response the DUT presents.
module tb_vec_inst_dispatcher;
  import vec_inst_dispatcher_pkg::*;

  typedef struct packed {
    logic        err;
    logic        isvec;
    logic [31:0] csr;
  } resp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_inst_dispatcher_if bus();

`ifdef DISPATCH_STATS_EN
  logic        stats_clr;
  logic [15:0] issue_count;
  logic [15:0] err_count;
`endif

  vec_inst_dispatcher #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DISPATCH_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .issue_count (issue_count),
    .err_count   (err_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  fifo_entry_t exp_issue[$];
  resp_t       exp_resp[$];

  // vector processor model knobs
  int          m_delay  = 1;
  int          m_hold   = 1;
  logic        m_err    = 1'b0;
  logic        m_isvec  = 1'b1;
  logic [31:0] m_csr    = 32'h0;
  bit          m_enable = 1'b1;
  int          m_phase  = 0;
  int          m_cnt    = 0;

  // monitor state
  int          iv_run = 0;
  int          spr_run = 0;
  int          rv_run = 0;
  int          issued = 0;
  logic        last_err = 1'b0;
  logic        last_isvec = 1'b0;
  logic [31:0] last_csr = 32'h0;
  fifo_entry_t mon_e;
  resp_t       mon_r;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // monitor first, then the vector processor model, all on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      iv_run = 0; spr_run = 0; rv_run = 0;
      m_phase = 0; m_cnt = 0;
      bus.vec_pro_ack = 1'b0; bus.error = 1'b0; bus.is_vec = 1'b0; bus.csr_out = 32'h0;
    end else begin
      if (bus.inst_valid) begin
        issued++;
        chk("issue_while_busy", 32'(m_phase), 32'd0);
        if (exp_issue.size() == 0) chk("issue_unexpected", 32'(exp_issue.size()), 32'd1);
        else begin
          mon_e = exp_issue.pop_front();
          chk("issue_inst", bus.instruction, mon_e.inst);
          chk("issue_rs1", bus.rs1_data, mon_e.rs1);
          chk("issue_rs2", bus.rs2_data, mon_e.rs2);
        end
      end
      if (bus.inst_valid) iv_run++;
      else begin
        if (iv_run != 0) chk("inst_valid_width", 32'(iv_run), 32'd1);
        iv_run = 0;
      end
      if (bus.scalar_pro_ready) spr_run++;
      else begin
        if (spr_run != 0) chk("spr_cycles", 32'(spr_run), 32'(m_hold));
        spr_run = 0;
      end
      if (bus.resp_valid) rv_run++;
      else begin
        if (rv_run != 0) chk("resp_valid_width", 32'(rv_run), 32'd1);
        rv_run = 0;
      end
      if (bus.resp_valid) begin
        last_err = bus.resp_error; last_isvec = bus.resp_is_vec; last_csr = bus.resp_csr;
        if (exp_resp.size() == 0) chk("resp_unexpected", 32'(exp_resp.size()), 32'd1);
        else begin
          mon_r = exp_resp.pop_front();
          chk("resp_error", 32'(bus.resp_error), 32'(mon_r.err));
          chk("resp_is_vec", 32'(bus.resp_is_vec), 32'(mon_r.isvec));
          chk("resp_csr", bus.resp_csr, mon_r.csr);
        end
      end
      case (m_phase)
        0: if (bus.inst_valid && m_enable) begin m_cnt = m_delay; m_phase = 1; end
        1: if (m_cnt == 0) begin
             bus.vec_pro_ack = 1'b1; bus.error = m_err; bus.is_vec = m_isvec; bus.csr_out = m_csr;
             exp_resp.push_back('{err: m_err, isvec: m_isvec, csr: m_csr});
             m_cnt = m_hold - 1; m_phase = 2;
           end else m_cnt--;
        default: if (m_cnt == 0) begin
             bus.vec_pro_ack = 1'b0; bus.error = 1'b0; bus.is_vec = 1'b0; bus.csr_out = 32'h0;
             m_phase = 0;
           end else m_cnt--;
      endcase
    end
  end

  // called on a falling edge; returns on the falling edge after acceptance
  task automatic do_push(input logic [31:0] i_inst, input logic [31:0] i_rs1,
                         input logic [31:0] i_rs2, input int budget);
    int t = 0;
    bus.push_valid = 1'b1; bus.push_inst = i_inst; bus.push_rs1 = i_rs1; bus.push_rs2 = i_rs2;
    while (!bus.push_ready && t < budget) begin @(negedge clk); t++; end
    if (!bus.push_ready) chk("push_timeout", 32'(bus.push_ready), 32'd1);
    else exp_issue.push_back('{inst: i_inst, rs1: i_rs1, rs2: i_rs2});
    @(negedge clk);
    bus.push_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clk);
    while (bus.busy && t < budget) begin @(negedge clk); t++; end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
    @(negedge clk);
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic clear_stats();
    stats_clr = 1'b1; @(negedge clk); stats_clr = 1'b0;
  endtask
`endif

  int base;

  initial begin
    reset = 1'b0;
    bus.push_valid = 1'b0; bus.push_inst = '0; bus.push_rs1 = '0; bus.push_rs2 = '0;
    bus.vec_pro_ready = 1'b1; bus.vec_pro_ack = 1'b0;
    bus.error = 1'b0; bus.is_vec = 1'b0; bus.csr_out = '0;
`ifdef DISPATCH_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_instruction", bus.instruction, 32'd0);
    chk("rst_spr", 32'(bus.scalar_pro_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_csr", bus.resp_csr, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // single instruction, latency and response fields
    m_hold = 1; m_err = 1'b0; m_isvec = 1'b1; m_csr = 32'h0000_0A5A;
    do_push(32'h0200_7057, 32'h0000_0010, 32'h0, 10);
    chk("lat_edge_n", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge_n1", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge_n2", 32'(bus.inst_valid), 32'd1);
    chk("a_instruction", bus.instruction, 32'h0200_7057);
    chk("a_rs1", bus.rs1_data, 32'h0000_0010);
    wait_idle(50);
    chk("a_resp_is_vec", 32'(last_isvec), 32'd1);
    chk("a_resp_error", 32'(last_err), 32'd0);
    chk("a_hold_data", bus.instruction, 32'h0200_7057);

    // ack held three cycles
    m_hold = 3; m_isvec = 1'b0; m_csr = 32'h0000_0C0C;
    do_push(32'h0220_8057, 32'h1, 32'h2, 10);
    wait_idle(50);
    chk("c_resp_csr", last_csr, 32'h0000_0C0C);
    chk("c_resp_is_vec", 32'(last_isvec), 32'd0);

    // error response
`ifdef DISPATCH_STATS_EN
    clear_stats();
`endif
    m_hold = 1; m_err = 1'b1; m_isvec = 1'b1; m_csr = 32'hDEAD_BEEF;
    do_push(32'h0000_0057, 32'h3, 32'h4, 10);
    wait_idle(50);
    chk("d_resp_error", 32'(last_err), 32'd1);
    chk("d_resp_csr", last_csr, 32'hDEAD_BEEF);
`ifdef DISPATCH_STATS_EN
    chk("d_err_count", 32'(err_count), 32'd1);
    chk("d_issue_count", 32'(issue_count), 32'd1);
`endif

    // fill to full while the vector unit is not ready
    m_err = 1'b0; m_csr = 32'h0000_0005;
    bus.vec_pro_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_push(32'h1000_0057 + 32'(i) * 32'h100, 32'(i), 32'(i + 16), 10);
    chk("b_full_ready", 32'(bus.push_ready), 32'd0);
    bus.push_valid = 1'b1; bus.push_inst = 32'h1000_0457; bus.push_rs1 = 32'h4; bus.push_rs2 = 32'h14;
    repeat (2) @(negedge clk);
    chk("b_held_off", 32'(bus.push_ready), 32'd0);
    bus.vec_pro_ready = 1'b1;
    @(negedge clk);
    chk("b_accept_ready", 32'(bus.push_ready), 32'd1);
    chk("b_accept_after_issue", 32'(bus.inst_valid), 32'd1);
    exp_issue.push_back('{inst: 32'h1000_0457, rs1: 32'h4, rs2: 32'h14});
    @(negedge clk);
    bus.push_valid = 1'b0;
    wait_idle(200);

    // eight back to back, pointers wrap
`ifdef DISPATCH_STATS_EN
    clear_stats();
`endif
    m_delay = 0;
    base = issued;
    for (int i = 0; i < 8; i++)
      do_push(32'h2000_0057 + 32'(i) * 32'h1000, 32'(i + 100), 32'(i + 200), 100);
    wait_idle(400);
    chk("f_issued", 32'(issued - base), 32'd8);
`ifdef DISPATCH_STATS_EN
    chk("f_issue_count", 32'(issue_count), 32'd8);
    chk("f_err_count", 32'(err_count), 32'd0);
`endif

    // reset in WAIT_ACK with two entries queued
    m_enable = 1'b0; m_delay = 1;
    base = issued;
    do_push(32'h3000_0057, 32'h1, 32'h1, 10);
    do_push(32'h3100_0057, 32'h2, 32'h2, 10);
    do_push(32'h3200_0057, 32'h3, 32'h3, 10);
    repeat (8) @(negedge clk);
    chk("e_issued_one", 32'(issued - base), 32'd1);
    reset = 1'b0;
    exp_issue.delete(); exp_resp.delete();
    #1;
    chk("e_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("e_instruction", bus.instruction, 32'd0);
    chk("e_resp_csr", bus.resp_csr, 32'd0);
    chk("e_push_ready", 32'(bus.push_ready), 32'd1);
    chk("e_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_enable = 1'b1;
    base = issued;
    repeat (10) @(negedge clk);
    chk("e_no_issue", 32'(issued - base), 32'd0);
    chk("e_idle_after", 32'(bus.busy), 32'd0);
    do_push(32'h3300_0057, 32'h5, 32'h6, 10);
    wait_idle(50);
    chk("e_reissue", 32'(issued - base), 32'd1);

    // reset mid-handshake drops scalar_pro_ready at once
    m_hold = 20;
    do_push(32'h3400_0057, 32'h7, 32'h8, 10);
    begin
      int t = 0;
      while (!bus.scalar_pro_ready && t < 50) begin @(negedge clk); t++; end
      chk("h_reach_handshake", 32'(bus.scalar_pro_ready), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_issue.delete(); exp_resp.delete();
    #1;
    chk("h_spr_async", 32'(bus.scalar_pro_ready), 32'd0);
    chk("h_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hold = 1;
    repeat (3) @(negedge clk);

    chk("end_issue_queue", 32'(exp_issue.size()), 32'd0);
    chk("end_resp_queue", 32'(exp_resp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vec_inst_dispatcher.md
VEC_INST_DISPATCHER -- requirements
Module: vec_inst_dispatcher

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction FIFO entry count (power of 2, at least 2).
REQ-002 Port clk, input, 1, SHALL be the single rising-edge clock.
REQ-003 Port reset, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Ports push_inst / push_rs1 / push_rs2, input, 32 each, SHALL carry the instruction and scalar operands from the scalar core.
REQ-005 Ports push_valid (input, 1) and push_ready (output, 1) SHALL form the enqueue handshake; a push is accepted when both are high.
REQ-006 Ports instruction / rs1_data / rs2_data, output, 32 each, SHALL drive the vector processor.
REQ-007 Port inst_valid, output, 1, SHALL be the issue strobe to the vector processor.
REQ-008 Port vec_pro_ready, input, 1, SHALL indicate the vector processor can accept an instruction.
REQ-009 Port vec_pro_ack, input, 1, SHALL indicate the vector processor has completed an instruction.
REQ-010 Port scalar_pro_ready, output, 1, SHALL be the completion acknowledge returned to the vector processor.
REQ-011 Ports error / is_vec (input, 1 each) and csr_out (input, 32) SHALL be the vector result status.
REQ-012 Ports resp_valid (output, 1), resp_error (output, 1), resp_is_vec (output, 1) and resp_csr (output, 32) SHALL return the result to the scalar core.
REQ-013 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-014 push_ready SHALL equal !full; a push presented while full SHALL be ignored, even if a pop occurs in the same cycle.
REQ-015 Pointers SHALL be log2(DEPTH) bits wide plus one wrap bit, and SHALL wrap modulo DEPTH.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_ACK and HANDSHAKE.
REQ-017 IDLE: when the FIFO is non-empty and vec_pro_ready=1, the FSM SHALL pop the head, register it onto instruction/rs1_data/rs2_data, and go to ISSUE.
REQ-018 ISSUE: inst_valid SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT_ACK.
REQ-019 Data outputs SHALL hold their values until the next pop.
REQ-020 WAIT_ACK: on vec_pro_ack=1 the FSM SHALL capture error, is_vec and csr_out into the resp_* registers and go to HANDSHAKE; otherwise it SHALL stay in WAIT_ACK.
REQ-021 HANDSHAKE: scalar_pro_ready SHALL be 1 on every cycle spent in HANDSHAKE.
REQ-022 resp_valid SHALL pulse high for only the first HANDSHAKE cycle.
REQ-023 HANDSHAKE exit: when vec_pro_ack=0, the FSM SHALL go to IDLE and scalar_pro_ready SHALL be 0 from the next cycle.
REQ-024 Latency: with the FIFO empty and vec_pro_ready=1, a push accepted at edge N SHALL give inst_valid=1 in the cycle after edge N+2.
REQ-025 A vec_pro_ack seen outside WAIT_ACK SHALL be ignored.
REQ-026 Pushes SHALL continue to be accepted in every FSM state.

Reset
REQ-027 While reset=0, the FIFO SHALL be emptied, the FSM forced to IDLE, and all outputs set to 0, except push_ready, which SHALL be 1.
REQ-028 A reset asserted mid-handshake SHALL drop inst_valid and scalar_pro_ready asynchronously and discard the in-flight and queued instructions.

Configuration
REQ-029 With DISPATCH_STATS_EN defined, outputs issue_count[15:0] and err_count[15:0] SHALL exist; each ISSUE SHALL increment issue_count and each captured error=1 SHALL increment err_count.
REQ-030 Both counters SHALL saturate at 16'hFFFF.
REQ-031 Input stats_clr SHALL clear both counters synchronously and SHALL take priority over an increment in the same cycle.
REQ-032 Without DISPATCH_STATS_EN, the counters and stats_clr SHALL not exist and the remaining behaviour SHALL be identical.

Structure
REQ-033 The shared package SHALL define the dispatch FSM state enum and the FIFO entry struct {inst, rs1, rs2}, 96 bits.
REQ-034 The FIFO SHALL be a separate sub-module vec_inst_fifo (push/pop, full/empty, DEPTH parameter); the FSM, response capture and counters SHALL live in vec_inst_dispatcher.

Verification
REQ-035 Single push 0x0200_7057 with rs1=0x10 and a ready model -> inst_valid high exactly one cycle with instruction=0x0200_7057, then resp_valid pulse with resp_is_vec=1, resp_error=0.
REQ-036 Push 5 instructions with DEPTH=4 while vec_pro_ready=0 -> push_ready=0 after the 4th push; the 5th is held off, then accepted after the first issue.
REQ-037 Model holds vec_pro_ack high for 3 cycles -> scalar_pro_ready high for 3 cycles, resp_valid high for 1 cycle, no second issue until ack drops.
REQ-038 Model returns error=1 with csr_out=0xDEAD_BEEF -> resp_error=1 and resp_csr=0xDEAD_BEEF; err_count=1 when DISPATCH_STATS_EN is defined.
REQ-039 Assert reset in WAIT_ACK with 2 entries queued -> outputs 0, push_ready=1, and no issue after release until a new push.
REQ-040 Issue 8 instructions back to back with DEPTH=4 -> pointer wrap-around exercised, all 8 issued in push order, and issue_count=8 when DISPATCH_STATS_EN is defined.
